// File: rtl/scan_decoder_n.sv
// Registered N-to-2**N one-hot decoder with a loadable index that can auto-scan at a prescaled rate.
// Define SCAN_DECODER_PINGPONG_EN to make the scan bounce between the ends instead of wrapping.
module scan_decoder_n #(
  parameter int unsigned N   = 2,
  parameter int unsigned DIV = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic            load,
  input  logic [N-1:0]    w,
  input  logic            scan,
  input  logic            dir,
  output logic [2**N-1:0] o,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int unsigned OW = 2**N;
  // DIV=1 still needs a 1-bit prescaler; it simply stays at zero.
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PreLast = PW'(DIV - 1);
  localparam logic [N-1:0]  IdxTop  = {N{1'b1}};

  logic [N-1:0]  idx_q, idx_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [OW-1:0] o_q, o_d;
  logic          wrap_q, wrap_d;
  logic          step;
`ifdef SCAN_DECODER_PINGPONG_EN
  logic          dir_q, dir_d;
`endif

  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    step   = 1'b0;
`ifdef SCAN_DECODER_PINGPONG_EN
    dir_d  = dir_q;
`endif
    if (load) begin
      idx_d = w;
      pre_d = '0;
`ifdef SCAN_DECODER_PINGPONG_EN
      dir_d = dir;
`endif
    end else if (scan && en) begin
      if (pre_q == PreLast) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (step) begin
`ifdef SCAN_DECODER_PINGPONG_EN
      if (dir_q) begin
        if (idx_q == IdxTop) begin
          idx_d  = idx_q - 1'b1;
          dir_d  = 1'b0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          idx_d  = idx_q + 1'b1;
          dir_d  = 1'b1;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
`else
      if (dir) begin
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == IdxTop);
      end else begin
        idx_d  = idx_q - 1'b1;
        wrap_d = (idx_q == '0);
      end
`endif
    end

    // Output decodes the index value taken at this same edge.
    o_d = en ? (OW'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q  <= '0;
      pre_q  <= '0;
      o_q    <= '0;
      wrap_q <= 1'b0;
`ifdef SCAN_DECODER_PINGPONG_EN
      dir_q  <= 1'b1;
`endif
    end else begin
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      o_q    <= o_d;
      wrap_q <= wrap_d;
`ifdef SCAN_DECODER_PINGPONG_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign o    = o_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
